// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared FSM state type, counter sizing and idle level
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Level on the serial line between words; the detector bench relies on it too.
  localparam logic IDLE_BIT_DEFAULT = 1'b1;

  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out stage with a one-word hold buffer
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             serial_q, serial_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_start_q, frame_start_d;

  logic             accept;
  logic             load;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] shifted;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Ready depends only on registered state, never on in_valid.
  assign in_ready  = !hold_full_q;
  assign accept    = in_valid && !hold_full_q;
  assign load_word = hold_full_q ? hold_q : in_data;
  assign shifted   = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};

  always_comb begin
    state_d       = state_q;
    sreg_d        = sreg_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    serial_d      = IDLE_BIT;
    bit_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    load          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q || accept) load = 1'b1;
      end
      ST_SHIFT: begin
        if (cnt_q == LAST) begin
          // A queued word wins; otherwise a fresh word bypasses the hold buffer.
          if (hold_full_q || accept) load = 1'b1;
          else state_d = ST_IDLE;
        end else begin
          sreg_d      = shifted;
          cnt_d       = cnt_q + CW'(1);
          serial_d    = first_bit(shifted);
          bit_valid_d = 1'b1;
          if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d       = ST_SHIFT;
      sreg_d        = load_word;
      cnt_d         = '0;
      hold_full_d   = 1'b0;
      serial_d      = first_bit(load_word);
      bit_valid_d   = 1'b1;
      frame_start_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sreg_q        <= '0;
      cnt_q         <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      serial_q      <= IDLE_BIT;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sreg_q        <= sreg_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      serial_q      <= serial_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign serial_out  = serial_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q == ST_SHIFT) || hold_full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer (MSB- and LSB-first instances)
module tb_piso_serializer;
  import piso_serializer_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         rdy_m, so_m, bv_m, fs_m, busy_m;
  logic         rdy_l, so_l, bv_l, fs_l, busy_l;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_BIT_DEFAULT)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
    .serial_out(so_m), .bit_valid(bv_m), .frame_start(fs_m), .busy(busy_m));

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE_BIT_DEFAULT)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
    .serial_out(so_l), .bit_valid(bv_l), .frame_start(fs_l), .busy(busy_l));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // seq_* lists serial_out for cycles N+1..N+8, first bit in position 7.
  typedef struct {
    logic [7:0] data;
    logic [7:0] seq_m;
    logic [7:0] seq_l;
  } vec_t;
  vec_t tbl[5];

  typedef struct {
    logic bm;
    logic bl;
    logic fs;
  } mb_t;

  task automatic run_single(input vec_t v);
    @(negedge clk);
    chk("single_ready_m", rdy_m, 1);
    chk("single_ready_l", rdy_l, 1);
    in_data  = v.data;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("single_%0h_so_m_b%0d", v.data, i), so_m, v.seq_m[7-i]);
      chk($sformatf("single_%0h_so_l_b%0d", v.data, i), so_l, v.seq_l[7-i]);
      chk($sformatf("single_%0h_bv_b%0d", v.data, i), {bv_m, bv_l}, 2'b11);
      chk($sformatf("single_%0h_fs_b%0d", v.data, i), {fs_m, fs_l}, (i == 0) ? 2'b11 : 2'b00);
      chk($sformatf("single_%0h_busy_b%0d", v.data, i), {busy_m, busy_l}, 2'b11);
      @(negedge clk);
    end
    chk($sformatf("single_%0h_idle_so", v.data), {so_m, so_l}, 2'b11);
    chk($sformatf("single_%0h_idle_bv", v.data), {bv_m, bv_l}, 2'b00);
    chk($sformatf("single_%0h_idle_busy", v.data), {busy_m, busy_l}, 2'b00);
  endtask

  initial begin
    logic [7:0]  words[3];
    logic [29:0] log_so_m, log_so_l, log_bv, log_fs;
    logic        pend;
    int          idx;
    mb_t         q[$];
    mb_t         e;
    logic        cur_v, cur_bm, cur_bl, cur_fs;
    logic        model_rdy, acc, last_acc;
    int          pct;

    tbl[0] = '{8'hB4, 8'b1011_0100, 8'b0010_1101};
    tbl[1] = '{8'h01, 8'b0000_0001, 8'b1000_0000};
    tbl[2] = '{8'hAA, 8'b1010_1010, 8'b0101_0101};
    tbl[3] = '{8'h3C, 8'b0011_1100, 8'b0011_1100};
    tbl[4] = '{8'h0F, 8'b0000_1111, 8'b1111_0000};

    repeat (2) @(negedge clk);
    chk("reset_so", {so_m, so_l}, 2'b11);
    chk("reset_bv", {bv_m, bv_l}, 2'b00);
    chk("reset_fs", {fs_m, fs_l}, 2'b00);
    chk("reset_busy", {busy_m, busy_l}, 2'b00);
    chk("reset_ready", {rdy_m, rdy_l}, 2'b11);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 5; t++) run_single(tbl[t]);

    // Back-to-back words with in_valid held: 24 contiguous data bits.
    words[0] = 8'h0F; words[1] = 8'hF0; words[2] = 8'h33;
    log_so_m = '0; log_so_l = '0; log_bv = '0; log_fs = '0;
    idx = 0;
    @(negedge clk);
    in_data  = words[0];
    in_valid = 1'b1;
    pend     = rdy_m;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      log_so_m = {log_so_m[28:0], so_m};
      log_so_l = {log_so_l[28:0], so_l};
      log_bv   = {log_bv[28:0], bv_m & bv_l};
      log_fs   = {log_fs[28:0], fs_m & fs_l};
      if (pend) begin
        idx++;
        if (idx < 3) in_data = words[idx];
        else in_valid = 1'b0;
      end
      pend = in_valid && rdy_m;
    end
    chk("b2b_so_m", log_so_m, {24'h0FF033, 6'h3F});
    chk("b2b_so_l", log_so_l, {24'hF00FCC, 6'h3F});
    chk("b2b_bit_valid", log_bv, {24'hFFFFFF, 6'h00});
    chk("b2b_frame_start", log_fs, 30'b10000000_10000000_10000000_000000);
    chk("b2b_words_taken", idx, 3);

    // Reset in the middle of 8'hAA with 8'h55 sitting in the hold buffer.
    @(negedge clk);
    in_data  = 8'hAA;
    in_valid = 1'b1;
    @(negedge clk);
    in_data  = 8'h55;
    @(negedge clk);
    in_valid = 1'b0;
    chk("midrst_hold_ready", {rdy_m, rdy_l}, 2'b00);
    chk("midrst_hold_busy", {busy_m, busy_l}, 2'b11);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_so", {so_m, so_l}, 2'b11);
    chk("midrst_bv", {bv_m, bv_l}, 2'b00);
    chk("midrst_fs", {fs_m, fs_l}, 2'b00);
    chk("midrst_busy", {busy_m, busy_l}, 2'b00);
    chk("midrst_ready", {rdy_m, rdy_l}, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_idle_so", {so_m, so_l}, 2'b11);
    chk("postrst_idle_bv", {bv_m, bv_l}, 2'b00);
    run_single(tbl[3]);

    // Random traffic against a bit-queue model: accepted words append their bits,
    // one bit leaves per cycle, and a word is waiting whenever >= W bits are queued.
    q.delete();
    cur_v = 1'b0; cur_bm = 1'b0; cur_bl = 1'b0; cur_fs = 1'b0;
    last_acc = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      chk("rnd_so_m", so_m, cur_v ? cur_bm : 1'b1);
      chk("rnd_so_l", so_l, cur_v ? cur_bl : 1'b1);
      chk("rnd_bv", {bv_m, bv_l}, {cur_v, cur_v});
      chk("rnd_fs", {fs_m, fs_l}, {cur_v && cur_fs, cur_v && cur_fs});
      chk("rnd_busy", {busy_m, busy_l}, (cur_v || q.size() >= W) ? 2'b11 : 2'b00);
      chk("rnd_ready", {rdy_m, rdy_l}, (q.size() < W) ? 2'b11 : 2'b00);
      if (cyc == 1500) begin
        #2 rst_n = 1'b0;
        #1 chk("rnd_rst_busy", {busy_m, busy_l}, 2'b00);
        #1 rst_n = 1'b1;
        q.delete();
        cur_v    = 1'b0;
        in_valid = 1'b0;
        last_acc = 1'b1;
      end
      model_rdy = (q.size() < W);
      pct = ((cyc / 300) % 2 == 1) ? 95 : 30;
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(0, 99) < pct);
        in_data  = W'($urandom);
      end
      acc = in_valid && model_rdy;
      last_acc = acc;
      @(posedge clk);
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          e.bm = in_data[W-1-i];
          e.bl = in_data[i];
          e.fs = (i == 0);
          q.push_back(e);
        end
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        cur_v = 1'b1; cur_bm = e.bm; cur_bl = e.bl; cur_fs = e.fs;
      end else begin
        cur_v = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
